// File: rtl/piso_hs.sv
// piso_hs: parallel-in / serial-out shifter with a strobed bit advance.
// Frames carry WIDTH bits in the order selected by lsb_first, which is
// latched when the word is accepted. A new word can be taken on the edge
// that ends the current frame, so frames can run back-to-back with no gap.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit
// (the XOR of the latched word) to every frame.
module piso_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lsb_first,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PISO_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             lsb_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             ser_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic             at_last_data;
    logic             at_last;
    logic             advance;
    logic             accept;

    // Frame position decode: last data bit, last frame bit, advance strobe
    always_comb begin
        at_last_data = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));
`ifdef PISO_PARITY_EN
        at_last      = (state == PARITY);
`else
        at_last      = at_last_data;
`endif
        advance      = (state != IDLE) && ser_en;
    end

    // Handshake: ready when idle or when the final bit is being retired
    always_comb begin
        in_ready = !reset && ((state == IDLE) || (at_last && ser_en));
        accept   = in_valid && in_ready;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ser_en && at_last_data) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (ser_en) state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        ser_out   = ser_q;
        ser_valid = (state != IDLE);
        busy      = (state != IDLE);
        done      = at_last;
    end

    // Datapath: the shift register always holds the not-yet-presented bits at
    // the outgoing end, so ser_q is reloaded from shreg[1] or shreg[WIDTH-2]
    // on each advance while the register moves by one position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            lsb_q   <= 1'b0;
            bit_cnt <= '0;
            ser_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            shreg   <= in_data;
            lsb_q   <= lsb_first;
            bit_cnt <= '0;
            ser_q   <= lsb_first ? in_data[0] : in_data[WIDTH-1];
`ifdef PISO_PARITY_EN
            par_q   <= ^in_data;
`endif
        end else if (advance) begin
            if (at_last) begin
                ser_q <= 1'b0;
`ifdef PISO_PARITY_EN
            end else if (at_last_data) begin
                ser_q <= par_q;
`endif
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (lsb_q) begin
                    shreg <= shreg >> 1;
                    ser_q <= shreg[1];
                end else begin
                    shreg <= shreg << 1;
                    ser_q <= shreg[WIDTH-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_hs.sv
// Testbench for piso_hs: fixed vector table, hand-written multi-cycle
// sequences and a randomized run, all checked against a queue-based
// reference model of the serial stream. Honours PISO_PARITY_EN.
module tb_piso_hs;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             lsb_first;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    piso_hs #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lsb_first (lsb_first),
        .ser_en    (ser_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining bits of the current frame, front = on the wire
    bit mq[$];

    // Outputs sampled during the most recent cycle
    logic s_out, s_valid, s_busy, s_done, s_ready;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             lsb;
        logic             en;
        logic             e_out;
        logic             e_valid;
        logic             e_done;
        logic             e_ready;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void load_frame(input logic [WIDTH-1:0] w, input logic lsb);
        mq.delete();
        for (int i = 0; i < WIDTH; i++) mq.push_back(lsb ? w[i] : w[WIDTH-1-i]);
`ifdef PISO_PARITY_EN
        mq.push_back(^w);
`endif
    endfunction

    // One clock cycle: drive, check against model before the edge, update model
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic lsb, input logic en);
        logic act;
        logic e_ready;
        logic e_out;
        in_valid  = v;
        in_data   = d;
        lsb_first = lsb;
        ser_en    = en;
        #2;
        act     = (mq.size() > 0);
        e_ready = !act || (mq.size() == 1 && en);
        e_out   = act ? mq[0] : 1'b0;
        s_out   = ser_out;
        s_valid = ser_valid;
        s_busy  = busy;
        s_done  = done;
        s_ready = in_ready;
        chk("ser_valid", {31'b0, ser_valid}, {31'b0, act});
        chk("busy",      {31'b0, busy},      {31'b0, act});
        chk("ser_out",   {31'b0, ser_out},   {31'b0, e_out});
        chk("done",      {31'b0, done},      {31'b0, act && mq.size() == 1});
        chk("in_ready",  {31'b0, in_ready},  {31'b0, e_ready});
        @(posedge clock);
        if (act && en) void'(mq.pop_front());
        if (v && e_ready) load_frame(d, lsb);
        #1;
    endtask

    initial begin : main
        logic [WIDTH-1:0] w;
        logic [15:0]      bits;
        logic [15:0]      rdy;
        int               vcnt;
        int               bcnt;
        logic             en;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        lsb_first = 1'b0;
        ser_en    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        // Outputs while reset is held
        chk("rst_ser_out",   {31'b0, ser_out},   0);
        chk("rst_ser_valid", {31'b0, ser_valid}, 0);
        chk("rst_busy",      {31'b0, busy},      0);
        chk("rst_done",      {31'b0, done},      0);
        chk("rst_in_ready",  {31'b0, in_ready},  0);
        reset = 1'b0;
        mq.delete();

`ifndef PISO_PARITY_EN
        // Fixed vectors: MSB-first then LSB-first frame of 8'b11111100
        w = 8'hFC;
        tbl[0] = '{1'b1, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, w[8-i], 1'b1, (i == 8), (i == 8)};
        tbl[9] = '{1'b1, 8'hFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 10; i <= 17; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, w[i-10], 1'b1, (i == 17), (i == 17)};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].lsb, tbl[i].en);
            chk($sformatf("tbl%0d_ser_out", i),   {31'b0, s_out},   {31'b0, tbl[i].e_out});
            chk($sformatf("tbl%0d_ser_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_done", i),      {31'b0, s_done},  {31'b0, tbl[i].e_done});
            chk($sformatf("tbl%0d_in_ready", i),  {31'b0, s_ready}, {31'b0, tbl[i].e_ready});
        end
`endif

        // Back-to-back: A5 then 3C offered early (ignored until the final bit)
        cycle(1'b1, 8'hA5, 1'b0, 1'b1);
        bits = '0; rdy = '0; vcnt = 0;
        for (int i = 0; i < 2 * FLEN; i++) begin
            cycle(i < FLEN, 8'h3C, 1'b0, 1'b1);
            bits = {bits[14:0], s_out};
            rdy[i] = s_ready;
            if (s_valid) vcnt++;
        end
        chk("b2b_valid_cycles", vcnt, 2 * FLEN);
`ifndef PISO_PARITY_EN
        chk("b2b_bits",  bits, 16'b1010010100111100);
        chk("b2b_ready", rdy,  16'b1000000010000000);
`endif

        // Strobed advance: ser_en high every third cycle
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        bits = '0; bcnt = 0;
        for (int c = 0; c < 3 * FLEN + 3; c++) begin
            en = ((c % 3) == 2);
            cycle(1'b0, 8'h00, 1'b0, en);
            if (s_busy) bcnt++;
            if (en && s_valid) bits = {bits[14:0], s_out};
        end
        chk("strobe_busy_cycles", bcnt, 3 * FLEN);
`ifdef PISO_PARITY_EN
        chk("strobe_bits", bits, {7'b0, 8'hA5, 1'b0});
`else
        chk("strobe_bits", bits, {8'b0, 8'hA5});
`endif

        // Asynchronous reset mid-frame, then a clean frame
        cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ser_out",   {31'b0, ser_out},   0);
        chk("abort_ser_valid", {31'b0, ser_valid}, 0);
        chk("abort_busy",      {31'b0, busy},      0);
        chk("abort_done",      {31'b0, done},      0);
        chk("abort_in_ready",  {31'b0, in_ready},  0);
        mq.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        bits = '0;
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (i < WIDTH) bits = {bits[14:0], s_out};
        end
        chk("post_abort_bits", bits, 16'h0001);

`ifdef PISO_PARITY_EN
        // Parity bit and done on the ninth bit
        cycle(1'b1, 8'hFC, 1'b0, 1'b1);
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (i == FLEN - 1) begin
                chk("par_fc_bit",  {31'b0, s_out},  0);
                chk("par_fc_done", {31'b0, s_done}, 1);
            end
        end
        cycle(1'b1, 8'h07, 1'b0, 1'b1);
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (i == FLEN - 1) begin
                chk("par_07_bit",  {31'b0, s_out},  1);
                chk("par_07_done", {31'b0, s_done}, 1);
            end
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 1) == 1), WIDTH'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 2 * FLEN; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
